// File: rtl/hex_disp_pkg.sv
// Shared 7-segment glyph definitions and capture FSM state type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hex_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } cap_state_t;

    // Active-low segment pattern for a dark digit.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs indexed by nibble value; entry 15 is leftmost.
    localparam logic [15:0][6:0] SEG7_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/hex_display_capture_if.sv
// Display-bus and captured-word handshake bundle for hex_display_capture.
// Latency: n/a (wiring only).
// Backpressure: Valid/Ready on the captured word; the display side has none.
interface hex_display_capture_if #(
    parameter int NDIG = 8
) ();

    logic [6:0]        Seg_n;
    logic [NDIG-1:0]   Dig_n;
    logic              Ready;
    logic              Valid;
    logic [4*NDIG-1:0] Value;
    logic [NDIG-1:0]   Err_mask;
    logic              Overrun;

    // Environment side: drives the display pins and consumes words.
    modport master (
        output Seg_n, Dig_n, Ready,
        input  Valid, Value, Err_mask, Overrun
    );

    // Capture side.
    modport slave (
        input  Seg_n, Dig_n, Ready,
        output Valid, Value, Err_mask, Overrun
    );

endinterface

// File: rtl/seg7_decode.sv
// Maps an active-low 7-segment pattern back to its hex nibble.
// Latency: combinational.
// Backpressure: none.
module seg7_decode
    import hex_disp_pkg::*;
(
    input  logic [6:0] i_seg_n,
    output logic [3:0] o_nibble,
    output logic       o_illegal
);

    // Search the shared glyph table; unmatched patterns (blank included) read as 0 with error.
    always_comb begin
        o_nibble  = 4'h0;
        o_illegal = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (i_seg_n == SEG7_GLYPH[k]) begin
                o_nibble  = 4'(k);
                o_illegal = 1'b0;
            end
        end
    end

endmodule

// File: rtl/hex_display_capture.sv
// Reads back a multiplexed active-low 7-seg display and assembles NDIG-digit words.
// Latency: digit accepted STABLE_CYC cycles after first sample; word valid 1 cycle after last accept edge.
// Backpressure: Valid/Ready; a word completing while Valid&&!Ready is dropped and sets sticky Overrun.
module hex_display_capture
    import hex_disp_pkg::*;
#(
    parameter int NDIG       = 8,
    parameter int STABLE_CYC = 4
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    hex_display_capture_if.slave bus
);

    localparam int CW = $clog2(STABLE_CYC);
    localparam int IW = $clog2(NDIG);
    // Count value at which one more identical sample completes the stability window.
    localparam logic [CW-1:0] ACC_CNT = CW'(STABLE_CYC - 2);

    // Input sample and previous sample
    logic [6:0]            r_smp_seg;
    logic [NDIG-1:0]       r_smp_dig;
    logic [6:0]            r_prv_seg;
    logic [NDIG-1:0]       r_prv_dig;

    // Capture FSM
    cap_state_t            r_state;
    logic [CW-1:0]         r_cnt;

    // Per-digit storage
    logic [NDIG-1:0][3:0]  r_slot;
    logic [NDIG-1:0]       r_slot_err;
    logic [NDIG-1:0]       r_mask;

    // Output register
    logic                  r_valid;
    logic [4*NDIG-1:0]     r_value;
    logic [NDIG-1:0]       r_err;
    logic                  r_overrun;

    logic [NDIG-1:0]       w_drv;
    logic                  w_onehot;
    logic                  w_same;
    logic [IW-1:0]         w_idx;
    logic [3:0]            w_nib;
    logic                  w_illegal;
    logic                  w_accept;
    logic                  w_complete;

    // Drive lines are active-low; flip so a driven digit is a 1 bit.
    assign w_drv      = ~r_smp_dig;
    assign w_onehot   = (w_drv != '0) && ((w_drv & (w_drv - NDIG'(1))) == '0);
    assign w_same     = (r_smp_seg == r_prv_seg) && (r_smp_dig == r_prv_dig);
    assign w_accept   = (r_state == SETTLE) && w_same && (r_cnt == ACC_CNT);
    assign w_complete = &r_mask;

    // Convert the one-hot drive vector to a slot index (only meaningful when one-hot).
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (w_drv[i]) begin
                w_idx = IW'(i);
            end
        end
    end

    seg7_decode u_decode (
        .i_seg_n   (r_smp_seg),
        .o_nibble  (w_nib),
        .o_illegal (w_illegal)
    );

    // Register the display pins once, then keep one older sample for change detection.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_smp_seg <= SEG_BLANK;
            r_smp_dig <= '1;
            r_prv_seg <= SEG_BLANK;
            r_prv_dig <= '1;
        end else begin
            r_smp_seg <= bus.Seg_n;
            r_smp_dig <= bus.Dig_n;
            r_prv_seg <= r_smp_seg;
            r_prv_dig <= r_smp_dig;
        end
    end

    // Stability FSM: wait for a one-hot digit, count identical samples, take it once, hold until change.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_onehot) begin
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!w_onehot) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (!w_same) begin
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                        if (r_cnt == ACC_CNT) begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!w_same) begin
                        r_state <= w_onehot ? SETTLE : IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Slot writes on accept; mask empties on completion, keeping only a same-edge accept bit.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_slot     <= '0;
            r_slot_err <= '0;
            r_mask     <= '0;
        end else begin
            if (w_accept) begin
                r_slot[w_idx]     <= w_nib;
                r_slot_err[w_idx] <= w_illegal;
            end
            r_mask <= (w_complete ? '0 : r_mask) | (w_accept ? w_drv : '0);
        end
    end

    // Output word register: load on completion when free or draining, else flag the drop.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_valid   <= 1'b0;
            r_value   <= '0;
            r_err     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_complete) begin
                if (!r_valid || bus.Ready) begin
                    r_valid <= 1'b1;
                    r_value <= r_slot;
                    r_err   <= r_slot_err;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && bus.Ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.Valid    = r_valid;
    assign bus.Value    = r_value;
    assign bus.Err_mask = r_err;
    assign bus.Overrun  = r_overrun;

endmodule

// File: tb/tb_hex_display_capture.sv
// Directed bench for hex_display_capture (NDIG=8, STABLE_CYC=4).
// Latency: n/a.
// Backpressure: bench drives Ready per scenario.
module tb_hex_display_capture;
    import hex_disp_pkg::*;

    logic Clk;
    logic Reset_n;

    hex_display_capture_if #(.NDIG(8)) bus ();

    hex_display_capture #(.NDIG(8), .STABLE_CYC(4)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string            name;
        logic [7:0][6:0]  seg;     // index = digit number
        logic [31:0]      value;
        logic [7:0]       err;
    } vec_t;

    vec_t        vecs [5];
    logic [39:0] words [$];   // {Err_mask, Value} of each accepted transfer
    int          npass  = 0;
    int          ntotal = 0;

    // Record every Valid&&Ready transfer, sampled mid-cycle.
    always @(negedge Clk) begin
        if (Reset_n && bus.Valid && bus.Ready) begin
            words.push_back({bus.Err_mask, bus.Value});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic drive_digit(input int idx, input logic [6:0] seg, input int n);
        logic [7:0] one;
        one = 8'h01;
        bus.Dig_n = ~(one << idx);
        bus.Seg_n = seg;
        tick(n);
    endtask

    task automatic blank(input int n);
        bus.Dig_n = 8'hFF;
        bus.Seg_n = SEG_BLANK;
        tick(n);
    endtask

    task automatic drive_frame(input logic [7:0][6:0] segs);
        for (int i = 0; i < 8; i++) drive_digit(i, segs[i], 6);
        blank(4);
    endtask

    // Check exactly one word arrived and it matches.
    task automatic chk_one_word(input string name, input logic [31:0] val, input logic [7:0] err);
        chk({name, ".count"}, 64'(words.size()), 64'd1);
        if (words.size() >= 1) begin
            chk({name, ".value"}, 64'(words[0][31:0]), 64'(val));
            chk({name, ".err"},   64'(words[0][39:32]), 64'(err));
        end else begin
            chk({name, ".value"}, 64'hDEAD_0000_0000, 64'(val));
            chk({name, ".err"},   64'hDEAD_0000_0000, 64'(err));
        end
    endtask

    initial begin
        logic [7:0][6:0] t1;
        int bad;

        // Segment tables written digit 7 first, digit 0 last.
        vecs[0] = '{"count18", {7'h00,7'h78,7'h02,7'h12,7'h19,7'h30,7'h24,7'h79}, 32'h87654321, 8'h00};
        vecs[1] = '{"blank5",  {7'h00,7'h78,7'h7F,7'h12,7'h19,7'h30,7'h24,7'h79}, 32'h87054321, 8'h20};
        vecs[2] = '{"deadbeef",{7'h21,7'h06,7'h08,7'h21,7'h03,7'h06,7'h06,7'h0E}, 32'hDEADBEEF, 8'h00};
        vecs[3] = '{"letters", {7'h40,7'h0E,7'h06,7'h21,7'h46,7'h03,7'h08,7'h10}, 32'h0FEDCBA9, 8'h00};
        vecs[4] = '{"illegal", {7'h55,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h7E}, 32'h00000000, 8'h81};
        t1 = vecs[0].seg;

        Reset_n   = 1'b0;
        bus.Dig_n = 8'hFF;
        bus.Seg_n = SEG_BLANK;
        bus.Ready = 1'b1;
        tick(3);
        chk("reset.valid",   64'(bus.Valid),    64'd0);
        chk("reset.value",   64'(bus.Value),    64'd0);
        chk("reset.err",     64'(bus.Err_mask), 64'd0);
        chk("reset.overrun", 64'(bus.Overrun),  64'd0);
        chk("reset.state",   64'(dut.r_state),  64'(IDLE));
        Reset_n = 1'b1;
        tick(2);

        // Table-driven frames with Ready held high.
        for (int v = 0; v < 5; v++) begin
            words.delete();
            drive_frame(vecs[v].seg);
            chk_one_word(vecs[v].name, vecs[v].value, vecs[v].err);
        end

        // Digit 3 glitches on '6' for 3 cycles (too short) before settling on '5'.
        words.delete();
        for (int i = 0; i < 3; i++) drive_digit(i, t1[i], 6);
        drive_digit(3, 7'h02, 3);
        drive_digit(3, 7'h12, 6);
        for (int i = 4; i < 8; i++) drive_digit(i, t1[i], 6);
        blank(4);
        chk_one_word("glitch3", 32'h87655321, 8'h00);

        // Two digits driven at once: must never leave IDLE or capture.
        words.delete();
        bus.Dig_n = 8'hFC;
        bus.Seg_n = 7'h40;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            if (dut.r_state != IDLE) bad++;
        end
        chk("multi.idle_cycles_bad", 64'(bad), 64'd0);
        chk("multi.mask", 64'(dut.r_mask), 64'd0);
        blank(2);
        drive_frame(t1);
        chk_one_word("after_multi", 32'h87654321, 8'h00);

        // Backpressure: second word dropped, Overrun sticky.
        words.delete();
        bus.Ready = 1'b0;
        drive_frame({8{7'h79}});
        chk("bp.valid1",   64'(bus.Valid),   64'd1);
        chk("bp.value1",   64'(bus.Value),   64'h11111111);
        chk("bp.overrun0", 64'(bus.Overrun), 64'd0);
        drive_frame({8{7'h24}});
        chk("bp.valid2",   64'(bus.Valid),   64'd1);
        chk("bp.value2",   64'(bus.Value),   64'h11111111);
        chk("bp.overrun1", 64'(bus.Overrun), 64'd1);
        chk("bp.no_xfer",  64'(words.size()), 64'd0);
        bus.Ready = 1'b1;
        @(negedge Clk);
        chk("bp.valid_before_edge", 64'(bus.Valid), 64'd1);
        tick(1);
        chk("bp.valid_dropped", 64'(bus.Valid),   64'd0);
        chk("bp.overrun_kept",  64'(bus.Overrun), 64'd1);
        chk_one_word("bp", 32'h11111111, 8'h00);

        // Reset mid-frame: partial upper digits must not leak into the next word.
        for (int i = 4; i < 8; i++) drive_digit(i, 7'h00, 6);
        bus.Dig_n = 8'hFF;
        bus.Seg_n = SEG_BLANK;
        Reset_n   = 1'b0;
        #1;
        chk("rst2.valid",   64'(bus.Valid),    64'd0);
        chk("rst2.value",   64'(bus.Value),    64'd0);
        chk("rst2.overrun", 64'(bus.Overrun),  64'd0);
        tick(3);
        Reset_n = 1'b1;
        words.delete();
        tick(2);
        drive_frame(vecs[2].seg);
        tick(4);
        chk_one_word("after_reset", 32'hDEADBEEF, 8'h00);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation still running, expected completion");
        $fatal(1);
    end

endmodule
